// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the fpg8 datapath: fetch/decode/execute micro-steps.
// One micro-step per enabled clock; run=0 freezes the step and masks every strobe.
module control_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [2:0] ALU_PASS    = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [2:0] ALU_control,
    output logic       GPR_in,
    output logic       GPR_out,
    output logic [2:0] GPR_select,
    output logic       IR_in,
    output logic       RAM_enable_read,
    output logic       RAM_enable_write,
    output logic       PC_out,
    output logic       PC_inc,
    output logic       MAR_in,
    output logic       MDR_in,
    output logic       MDR_out,
    output logic       Y_in,
    output logic       Z_in,
    output logic       Z_out,
    output logic       halted,
    output logic [2:0] t_state
);

    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [2:0] SEL_RD1 = 3'd0;
    localparam logic [2:0] SEL_RS1 = 3'd2;
    localparam logic [2:0] SEL_RS2 = 3'd3;
    localparam logic [2:0] ALU_NOT = 3'b110;

    state_t state_q, state_d;

    logic is_alu, is_unary, is_mem, strobe_en;

    assign is_alu    = (opcode >= 4'd1) && (opcode <= 4'd5);
    assign is_unary  = (opcode == 4'd6) || (opcode == 4'd7);
    assign is_mem    = (opcode == 4'd8) || (opcode == 4'd9);
    assign strobe_en = run & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                S_T0: state_d = S_T1;
                S_T1: state_d = S_T2;
                S_T2: state_d = S_T3;
                S_T3: begin
                    if (opcode == HALT_OPCODE)                state_d = S_HALT;
                    else if (is_alu || is_unary || is_mem)    state_d = S_T4;
                    else                                      state_d = S_T0;
                end
                S_T4: state_d = (is_alu || is_mem) ? S_T5 : S_T0;
                S_T5: state_d = S_T0;
                S_HALT: state_d = S_HALT;
                default: state_d = S_T0;
            endcase
        end
    end

    always_comb begin
        ALU_control      = ALU_PASS;
        GPR_in           = 1'b0;
        GPR_out          = 1'b0;
        GPR_select       = SEL_RD1;
        IR_in            = 1'b0;
        RAM_enable_read  = 1'b0;
        RAM_enable_write = 1'b0;
        PC_out           = 1'b0;
        PC_inc           = 1'b0;
        MAR_in           = 1'b0;
        MDR_in           = 1'b0;
        MDR_out          = 1'b0;
        Y_in             = 1'b0;
        Z_in             = 1'b0;
        Z_out            = 1'b0;
        if (strobe_en) begin
            case (state_q)
                S_T0: begin
                    PC_out = 1'b1;
                    MAR_in = 1'b1;
                end
                S_T1: begin
                    RAM_enable_read = 1'b1;
                    PC_inc          = 1'b1;
                end
                S_T2: begin
                    MDR_out = 1'b1;
                    IR_in   = 1'b1;
                end
                S_T3: begin
                    if (is_alu || is_unary || is_mem) begin
                        GPR_out    = 1'b1;
                        GPR_select = SEL_RS1;
                    end
                    if (is_alu) Y_in = 1'b1;
                    if (is_unary) begin
                        ALU_control = (opcode == 4'd6) ? ALU_NOT : ALU_PASS;
                        Z_in        = 1'b1;
                    end
                    if (is_mem) MAR_in = 1'b1;
                end
                S_T4: begin
                    if (is_alu) begin
                        GPR_out     = 1'b1;
                        GPR_select  = SEL_RS2;
                        ALU_control = opcode[2:0];
                        Z_in        = 1'b1;
                    end else if (is_unary) begin
                        Z_out  = 1'b1;
                        GPR_in = 1'b1;
                    end else if (opcode == 4'd8) begin
                        RAM_enable_read = 1'b1;
                    end else if (opcode == 4'd9) begin
                        GPR_out = 1'b1;
                        MDR_in  = 1'b1;
                    end
                end
                S_T5: begin
                    if (is_alu) begin
                        Z_out  = 1'b1;
                        GPR_in = 1'b1;
                    end else if (opcode == 4'd8) begin
                        MDR_out = 1'b1;
                        GPR_in  = 1'b1;
                    end else if (opcode == 4'd9) begin
                        RAM_enable_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted  = (state_q == S_HALT);
    assign t_state = state_q;

endmodule
